// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO and its read-side consumers.
// Holds the default data width and a constant-evaluable ceil(log2) helper
// used to size pointers and counters.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    // ceil(log2(value)), never less than 1 so a degenerate range still gets a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'(1) << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/frame_beat_counter.sv
// Frame boundary tracker for the read stream.
// Counts handshakes 0..FRAME_LEN-1, decodes the last beat of each frame and
// keeps a wrapping count of completed frames.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   valid          - stream valid (gates the last-beat decode)
//   handshake      - valid && ready this cycle
//   flush          - clears the beat position, keeps frame_count
//   last_c         - high on the final beat of a frame (decoded from state)
//   frame_count    - completed frames, wraps modulo 2^FCNT_WIDTH
module frame_beat_counter
    import fifo_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic                  handshake,
    input  logic                  flush,
    output logic                  last_c,
    output logic [FCNT_WIDTH-1:0] frame_count
);

    localparam int unsigned BEAT_W = clog2(FRAME_LEN);

    logic [BEAT_W-1:0]     beat_cnt_q;
    logic [BEAT_W-1:0]     beat_cnt_d;
    logic [FCNT_WIDTH-1:0] frame_count_q;
    logic [FCNT_WIDTH-1:0] frame_count_d;

    assign last_c      = valid && (beat_cnt_q == BEAT_W'(FRAME_LEN - 1));
    assign frame_count = frame_count_q;

    // A handshake in the flush cycle still happens but never completes a frame.
    always_comb begin
        beat_cnt_d    = beat_cnt_q;
        frame_count_d = frame_count_q;
        if (flush) begin
            beat_cnt_d = '0;
        end else if (handshake) begin
            if (last_c) begin
                beat_cnt_d    = '0;
                frame_count_d = frame_count_q + FCNT_WIDTH'(1);
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q    <= '0;
            frame_count_q <= '0;
        end else begin
            beat_cnt_q    <= beat_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter: pulls words from the FIFO (rd_en/empty/rd_data, 1-cycle
// read latency) into a small prefetch buffer and presents them as a
// valid/ready stream with frame markers.
// Ports:
//   rd_clk, rst_n  - read-domain clock, async active-low reset
//   fifo_empty     - FIFO empty flag
//   rd_data        - FIFO data, valid one cycle after rd_en
//   rd_en          - FIFO read strobe
//   flush          - synchronous clear of buffer, in-flight read, beat count
//   out_data/out_valid/out_ready - output stream
//   out_last       - final beat of a frame
//   frame_count    - completed frames
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = 3,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned FCNT_WIDTH = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [FCNT_WIDTH-1:0] frame_count
);

    localparam int unsigned PTR_W = clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      head_d;
    logic [PTR_W-1:0]      tail_q;
    logic [PTR_W-1:0]      tail_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  inflight_q;
    logic                  inflight_d;
    logic                  active_q;
    logic                  push_c;
    logic                  pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue only from registered occupancy so out_ready never reaches rd_en;
    // active_q holds rd_en low until the first edge after reset release.
    assign rd_en = active_q && !fifo_empty && !flush &&
                   ((SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(BUF_DEPTH));

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[head_q];
    assign push_c    = inflight_q && !flush;
    assign pop_c     = out_valid && out_ready;

    // Buffer pointer and occupancy next-state.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = rd_en;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else begin
            if (push_c) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop_c) begin
                head_d = ptr_inc(head_q);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            active_q   <= 1'b1;
        end
    end

    // Prefetch storage; cleared on reset so out_data reads zero.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[tail_q] <= rd_data;
        end
    end

    frame_beat_counter #(
        .FRAME_LEN  (FRAME_LEN),
        .FCNT_WIDTH (FCNT_WIDTH)
    ) u_frame (
        .clk         (rd_clk),
        .rst_n       (rst_n),
        .valid       (out_valid),
        .handshake   (pop_c),
        .flush       (flush),
        .last_c      (out_last),
        .frame_count (frame_count)
    );

    // The issue rule reserves a slot for every in-flight read.
    no_push_when_full: assert property (@(posedge rd_clk) disable iff (!rst_n)
        !(push_c && (count_q == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: startup vector table, framed
// streaming, backpressure, randomised empty/ready, flush and mid-frame reset.
module tb_fifo_rd_stream_adapter;

    localparam int unsigned FL = 16;

    logic        rd_clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [7:0]  rd_data;
    logic        rd_en;
    logic        flush;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] frame_count;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (8),
        .BUF_DEPTH  (3),
        .FRAME_LEN  (FL),
        .FCNT_WIDTH (16)
    ) dut (
        .rd_clk      (rd_clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .rd_data     (rd_data),
        .rd_en       (rd_en),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_count (frame_count)
    );

    // FIFO model: word i holds i[7:0]; words below wlim are available.
    int   rptr = 0;
    int   wlim = 0;
    logic empty_force = 1'b0;
    assign fifo_empty = (rptr >= wlim) || empty_force;

    logic [7:0] sbq [$];
    int         exp_beat   = 0;
    int         exp_frames = 0;
    int         n_hs       = 0;
    int         n_checks   = 0;
    int         n_fail     = 0;
    logic       last_rd    = 1'b0;
    logic [7:0] last_word  = 8'h00;
    logic       stall_p    = 1'b0;
    logic [7:0] stall_d    = 8'h00;
    logic       stall_l    = 1'b0;

    typedef struct {
        logic       rst_n;
        logic       empty;
        logic       ready;
        logic       flush;
        logic       exp_rd_en;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [7:0] word(input int i);
        return 8'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven; scores the
    // upcoming edge, runs the FIFO model and returns at the next negedge.
    task automatic cycle();
        logic       hs;
        logic       rd;
        logic       fl;
        logic       lst;
        logic [7:0] d;
        #1;
        hs  = out_valid && out_ready;
        rd  = rd_en;
        fl  = flush;
        d   = out_data;
        lst = out_last;
        if (stall_p) begin
            check("hold_data", 32'(d), 32'(stall_d));
            check("hold_last", 32'(lst), 32'(stall_l));
        end
        stall_p = out_valid && !out_ready && !fl && rst_n;
        stall_d = d;
        stall_l = lst;
        if (hs) begin
            n_hs++;
            if (sbq.size() == 0) begin
                check("sb_underflow", 32'(d), 32'hFFFF_FFFF);
            end else begin
                check("sb_data", 32'(d), 32'(sbq.pop_front()));
                check("sb_last", 32'(lst), 32'(exp_beat == FL - 1));
            end
            if (!fl) begin
                if (exp_beat == FL - 1) begin
                    exp_beat = 0;
                    exp_frames++;
                end else begin
                    exp_beat++;
                end
            end
        end
        if (fl) begin
            sbq.delete();
            exp_beat = 0;
        end
        @(posedge rd_clk);
        #1;
        last_rd = rd;
        if (rd) begin
            last_word = word(rptr);
            sbq.push_back(word(rptr));
            rd_data = word(rptr);
            rptr++;
        end else begin
            rd_data = 8'hEE;
        end
        @(negedge rd_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_hs=%0d", n_hs);
        $fatal(1, "watchdog");
    end

    initial begin
        int   beats;
        int   cyc;
        logic got_last;
        logic flushed;
        logic seen55;
        logic [7:0] held;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; rd_data = 8'h00; wlim = 48;

        //          rst   emp   rdy   fl    rd_en valid data   last
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};

        repeat (2) @(negedge rd_clk);

        // Reset and startup latency.
        for (int i = 0; i < 6; i++) begin
            rst_n = tbl[i].rst_n; empty_force = tbl[i].empty;
            out_ready = tbl[i].ready; flush = tbl[i].flush;
            #1;
            check($sformatf("vec%0d_rd_en", i), 32'(rd_en), 32'(tbl[i].exp_rd_en));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
            check($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].exp_last));
            if (i == 0) check("vec0_frame_count", 32'(frame_count), 32'd0);
            cycle();
        end

        // Remaining beats of 0x00..0x2F, one per cycle.
        for (int i = 2; i < 48; i++) begin
            #1;
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_last", 32'(out_last), 32'((i % 16) == 15));
            cycle();
        end
        repeat (3) cycle();
        check("stream_drained_valid", 32'(out_valid), 32'd0);
        check("stream_drained_rd_en", 32'(rd_en), 32'd0);
        check("stream_frame_count", 32'(frame_count), 32'd3);

        // Backpressure for 10 cycles once streaming is steady.
        wlim = 88;
        repeat (6) cycle();
        out_ready = 1'b0;
        held = 8'h00;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            if (k == 0) begin
                held = out_data;
            end else begin
                check("bp_rd_en", 32'(rd_en), 32'd0);
                check("bp_hold", 32'(out_data), 32'(held));
            end
            cycle();
        end
        out_ready = 1'b1;
        repeat (60) cycle();
        check("bp_beats", 32'(n_hs), 32'd88);
        check("bp_sb_empty", 32'(sbq.size()), 32'd0);

        // Empty pulsing 1-of-3 with random ready.
        void'($urandom(32'h00C0_FFEE));
        wlim = wlim + 2000;
        cyc  = 0;
        while (n_hs < 2088 && cyc < 20000) begin
            empty_force = (cyc % 3 == 0);
            out_ready   = 1'($urandom_range(0, 1));
            cycle();
            cyc++;
        end
        empty_force = 1'b0;
        check("rand_beats", 32'(n_hs), 32'd2088);
        check("rand_frame_count", 32'(frame_count), 32'(exp_frames));

        // Flush in the cycle word 0x55 arrives.
        out_ready = 1'b1;
        wlim = wlim + 300;
        flushed = 1'b0;
        for (int c = 0; c < 200 && !flushed; c++) begin
            if (last_rd && last_word == 8'h55) begin
                flush = 1'b1;
                cycle();
                flush = 1'b0;
                flushed = 1'b1;
            end else begin
                cycle();
            end
        end
        check("flush_hit", 32'(flushed), 32'd1);
        #1;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_frame_count", 32'(frame_count), 32'(exp_frames));
        beats = 0; got_last = 1'b0; seen55 = 1'b0;
        for (int c = 0; c < 100 && !got_last; c++) begin
            #1;
            if (out_valid && out_data == 8'h55) seen55 = 1'b1;
            if (out_valid && out_ready) begin
                beats++;
                if (out_last) got_last = 1'b1;
            end
            cycle();
        end
        check("flush_no_55", 32'(seen55), 32'd0);
        check("flush_last_beat", 32'(beats), 32'd16);

        // Reset at beat 7 of a frame.
        for (int c = 0; c < 100 && exp_beat != 7; c++) cycle();
        check("rst_reach_beat7", 32'(exp_beat), 32'd7);
        rst_n = 1'b0;
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        sbq.delete(); exp_beat = 0; exp_frames = 0; stall_p = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        beats = 0; got_last = 1'b0;
        for (int c = 0; c < 100 && !got_last; c++) begin
            #1;
            if (out_valid && out_ready) begin
                beats++;
                if (out_last) got_last = 1'b1;
            end
            cycle();
        end
        check("rst_last_beat", 32'(beats), 32'd16);
        #1;
        check("rst_frame_after", 32'(frame_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
